alu_op_decoder: RTL

ALU_OP_DECODER -- requirements
Module: alu_op_decoder

---
 rtl/alu_op_decoder_pkg.sv | 76 +++++++
 rtl/alu_op_decode_comb.sv | 119 +++++++++++
 rtl/alu_op_decoder.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_op_decoder_pkg.sv
// Shared ALUOp codes, RV32I opcode/funct3 encodings and the decoded bundle type.
// This is the single home of the xgriscv_defines encodings for the decoder slice.
package alu_op_decoder_pkg;

  localparam logic [4:0] ALU_LUI   = 5'd0;
  localparam logic [4:0] ALU_AUIPC = 5'd1;
  localparam logic [4:0] ALU_ADD   = 5'd2;
  localparam logic [4:0] ALU_SUB   = 5'd3;
  localparam logic [4:0] ALU_BNE   = 5'd4;
  localparam logic [4:0] ALU_BLT   = 5'd5;
  localparam logic [4:0] ALU_BGE   = 5'd6;
  localparam logic [4:0] ALU_BLTU  = 5'd7;
  localparam logic [4:0] ALU_BGEU  = 5'd8;
  localparam logic [4:0] ALU_SLT   = 5'd9;
  localparam logic [4:0] ALU_SLTU  = 5'd10;
  localparam logic [4:0] ALU_XOR   = 5'd11;
  localparam logic [4:0] ALU_OR    = 5'd12;
  localparam logic [4:0] ALU_AND   = 5'd13;
  localparam logic [4:0] ALU_SLL   = 5'd14;
  localparam logic [4:0] ALU_SRL   = 5'd15;
  localparam logic [4:0] ALU_SRA   = 5'd16;
  localparam logic [4:0] ALU_SLTI  = 5'd17;
  localparam logic [4:0] ALU_SLTIU = 5'd18;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [4:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        branch;
    logic        take_on_zero;
    logic        illegal;
  } dec_bundle_t;

endpackage

// File: rtl/alu_op_decode_comb.sv
// Purely combinational RV32I -> ALU bundle decode; no state.
module alu_op_decode_comb
  import alu_op_decoder_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output dec_bundle_t bundle
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_u, imm_j, shamt;
  logic        legal;
  logic        write_class;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign shamt  = {27'b0, instr[24:20]};

  always_comb begin
    bundle      = '0;
    bundle.pc   = pc;
    legal       = 1'b1;
    write_class = 1'b0;
    case (opcode)
      OP_LUI:   begin bundle.alu_op = ALU_LUI;   bundle.b = imm_u; write_class = 1'b1; end
      OP_AUIPC: begin bundle.alu_op = ALU_AUIPC; bundle.b = imm_u; write_class = 1'b1; end
      OP_JAL:   begin bundle.alu_op = ALU_AUIPC; bundle.b = imm_j; write_class = 1'b1; end
      OP_JALR: begin
        bundle.alu_op = ALU_ADD; bundle.a = rs1; bundle.b = imm_i; write_class = 1'b1;
        legal = (funct3 == F3_ADD);
      end
      OP_LOAD: begin
        bundle.alu_op = ALU_ADD; bundle.a = rs1; bundle.b = imm_i; write_class = 1'b1;
        legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                (funct3 == F3_LBU) || (funct3 == F3_LHU);
      end
      OP_STORE: begin
        bundle.alu_op = ALU_ADD; bundle.a = rs1; bundle.b = imm_s;
        legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
      end
      OP_IMM: begin
        bundle.a = rs1; bundle.b = imm_i; write_class = 1'b1;
        case (funct3)
          F3_ADD:  bundle.alu_op = ALU_ADD;
          F3_SLT:  bundle.alu_op = ALU_SLTI;
          F3_SLTU: bundle.alu_op = ALU_SLTIU;
          F3_XOR:  bundle.alu_op = ALU_XOR;
          F3_OR:   bundle.alu_op = ALU_OR;
          F3_AND:  bundle.alu_op = ALU_AND;
          F3_SLL: begin
            bundle.alu_op = ALU_SLL; bundle.b = shamt;
            legal = (funct7 == F7_BASE);
          end
          default: begin
            bundle.alu_op = instr[30] ? ALU_SRA : ALU_SRL; bundle.b = shamt;
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
        endcase
      end
      OP_OP: begin
        bundle.a = rs1; bundle.b = rs2; write_class = 1'b1;
        // Only add/sub and srl/sra accept the alternate funct7.
        legal = (funct7 == F7_BASE);
        case (funct3)
          F3_ADD: begin
            bundle.alu_op = instr[30] ? ALU_SUB : ALU_ADD;
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          F3_SLL:  bundle.alu_op = ALU_SLL;
          F3_SLT:  bundle.alu_op = ALU_SLT;
          F3_SLTU: bundle.alu_op = ALU_SLTU;
          F3_XOR:  bundle.alu_op = ALU_XOR;
          F3_OR:   bundle.alu_op = ALU_OR;
          F3_AND:  bundle.alu_op = ALU_AND;
          default: begin
            bundle.alu_op = instr[30] ? ALU_SRA : ALU_SRL;
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
        endcase
      end
      OP_BRANCH: begin
        bundle.a = rs1; bundle.b = rs2; bundle.branch = 1'b1;
        // bge/bgeu reuse the less-than compare and branch on a zero result.
        case (funct3)
          F3_BEQ:  begin bundle.alu_op = ALU_SUB;  bundle.take_on_zero = 1'b1; end
          F3_BNE:  bundle.alu_op = ALU_BNE;
          F3_BLT:  bundle.alu_op = ALU_BLT;
          F3_BGE:  begin bundle.alu_op = ALU_BLT;  bundle.take_on_zero = 1'b1; end
          F3_BLTU: bundle.alu_op = ALU_BLTU;
          F3_BGEU: begin bundle.alu_op = ALU_BLTU; bundle.take_on_zero = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      bundle         = '0;
      bundle.pc      = pc;
      bundle.alu_op  = ALU_ADD;
      bundle.illegal = 1'b1;
    end else if (write_class) begin
      bundle.rd        = rd;
      bundle.reg_write = (rd != 5'd0);
    end
  end

endmodule

// File: rtl/alu_op_decoder.sv
// Decode stage: one combinational decode plus the output handshake buffer.
// Define ALU_DEC_SKID_EN for a 2-entry skid buffer with registered in_ready.
module alu_op_decoder
  import alu_op_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_alu_op,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_branch,
  output logic        out_take_on_zero,
  output logic        out_illegal
);

  // Handshake: a word moves on any edge where valid&ready are both high on that
  // port; once out_valid rises, the bundle holds stable until out_ready accepts it.
  dec_bundle_t dec;
  dec_bundle_t out_q;
  logic        out_valid_q;
  logic        in_fire;

  alu_op_decode_comb u_decode (
    .instr  (in_instr),
    .pc     (in_pc),
    .rs1    (in_rs1_data),
    .rs2    (in_rs2_data),
    .bundle (dec)
  );

  assign in_fire = in_valid & in_ready;

`ifdef ALU_DEC_SKID_EN
  dec_bundle_t skid_q;
  logic        skid_valid_q;
  logic        in_ready_q;

  assign in_ready = rstn & in_ready_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      in_ready_q   <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      in_ready_q <= 1'b1;
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= in_fire;
        if (in_fire) out_q <= dec;
      end
    end else if (in_fire) begin
      // Output stalled: park the accepted word and close the input next cycle.
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
      in_ready_q   <= 1'b0;
    end else begin
      in_ready_q <= !skid_valid_q;
    end
  end
`else
  assign in_ready = rstn & (!out_valid_q | out_ready);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (!out_valid_q || out_ready) begin
      out_valid_q <= in_fire;
      if (in_fire) out_q <= dec;
    end
  end
`endif

  assign out_valid        = out_valid_q;
  assign out_alu_op       = out_q.alu_op;
  assign out_a            = out_q.a;
  assign out_b            = out_q.b;
  assign out_pc           = out_q.pc;
  assign out_rd           = out_q.rd;
  assign out_reg_write    = out_q.reg_write;
  assign out_branch       = out_q.branch;
  assign out_take_on_zero = out_q.take_on_zero;
  assign out_illegal      = out_q.illegal;

endmodule
